// File: rtl/mem_stage.sv
// Pipeline MEM stage: forwards EX results and performs LDW/SDW over a req/ack bus.
// Optional misalignment check enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int ADDR_W      = 30,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       val_rt_in,
  input  logic [4:0]        rwd_in,
  input  logic [5:0]        opcode_in,
  input  logic [31:0]       alu_res_in,
  output logic              stall,
  output logic [4:0]        rwd_out,
  output logic [5:0]        opcode_out,
  output logic [31:0]       alu_res_out,
  output logic [31:0]       mem_data_out,
  output logic              bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misalign_err
`endif
);

  localparam logic [5:0]  OP_LDW     = 6'h23;
  localparam logic [5:0]  OP_SDW     = 6'h2B;
  localparam logic [31:0] LOAD_ABORT = 32'hDEAD_BEEF;
  localparam logic [7:0]  TIMEOUT_V  = 8'(TIMEOUT_CYC);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYC != 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [4:0]         hold_rwd_q, hold_rwd_d;
  logic [5:0]         hold_op_q, hold_op_d;
  logic [31:0]        hold_alu_q, hold_alu_d;
  logic [4:0]         rwd_q, rwd_d;
  logic [5:0]         opcode_q, opcode_d;
  logic [31:0]        alu_res_q, alu_res_d;
  logic [31:0]        mem_data_q, mem_data_d;
  logic               bus_err_q, bus_err_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               misalign_q, misalign_d;
  logic               is_mem_s;
  logic               misaligned_s;
  logic               timeout_s;

  assign is_mem_s  = (opcode_in == OP_LDW) || (opcode_in == OP_SDW);
  assign timeout_s = TIMEOUT_EN && (cnt_q == TIMEOUT_V);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned_s = (alu_res_in[1:0] != 2'b00);
  assign misalign_err = misalign_q;
`else
  assign misaligned_s = 1'b0;
`endif

  // Next-state and output-register computation; bubble outputs unless retiring
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_rwd_d = hold_rwd_q;
    hold_op_d  = hold_op_q;
    hold_alu_d = hold_alu_q;
    rwd_d      = 5'd0;
    opcode_d   = 6'd0;
    alu_res_d  = 32'd0;
    mem_data_d = 32'd0;
    bus_err_d  = 1'b0;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    misalign_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (is_mem_s && !misaligned_s) begin
          hold_rwd_d = rwd_in;
          hold_op_d  = opcode_in;
          hold_alu_d = alu_res_in;
          req_d      = 1'b1;
          we_d       = (opcode_in == OP_SDW);
          addr_d     = alu_res_in[ADDR_W+1:2];
          wdata_d    = val_rt_in;
          cnt_d      = 8'd1;
          state_d    = ST_WAIT;
        end else begin
          // Misaligned memory ops retire here like ALU ops, flagged instead of issued
          rwd_d      = rwd_in;
          opcode_d   = opcode_in;
          alu_res_d  = alu_res_in;
          misalign_d = is_mem_s && misaligned_s;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          req_d      = 1'b0;
          rwd_d      = hold_rwd_q;
          opcode_d   = hold_op_q;
          alu_res_d  = hold_alu_q;
          mem_data_d = (hold_op_q == OP_LDW) ? dmem_rdata : 32'd0;
          cnt_d      = 8'd0;
          state_d    = ST_IDLE;
        end else if (timeout_s) begin
          req_d      = 1'b0;
          rwd_d      = hold_rwd_q;
          opcode_d   = hold_op_q;
          alu_res_d  = hold_alu_q;
          mem_data_d = (hold_op_q == OP_LDW) ? LOAD_ABORT : 32'd0;
          bus_err_d  = 1'b1;
          cnt_d      = 8'd0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        req_d   = 1'b0;
        cnt_d   = 8'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, hold and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      hold_rwd_q <= 5'd0;
      hold_op_q  <= 6'd0;
      hold_alu_q <= 32'd0;
      rwd_q      <= 5'd0;
      opcode_q   <= 6'd0;
      alu_res_q  <= 32'd0;
      mem_data_q <= 32'd0;
      bus_err_q  <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_rwd_q <= hold_rwd_d;
      hold_op_q  <= hold_op_d;
      hold_alu_q <= hold_alu_d;
      rwd_q      <= rwd_d;
      opcode_q   <= opcode_d;
      alu_res_q  <= alu_res_d;
      mem_data_q <= mem_data_d;
      bus_err_q  <= bus_err_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      misalign_q <= misalign_d;
    end
  end

`ifndef MEM_ALIGN_CHECK_EN
  logic unused_misalign_s;
  assign unused_misalign_s = misalign_q;
`endif

  assign stall        = (state_q == ST_WAIT);
  assign rwd_out      = rwd_q;
  assign opcode_out   = opcode_q;
  assign alu_res_out  = alu_res_q;
  assign mem_data_out = mem_data_q;
  assign bus_err      = bus_err_q;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;

endmodule
